// File: rtl/lut_sram_arbiter.sv
// Quarter-sine LUT SRAM arbiter: DDS lookups (fixed priority, 2-entry
// buffer) share one SPRAM with a host port guarded by a bounded wait.
// Ports:
//   clk, rst_n                : clock, async active-low reset
//   dds_req/dds_addr          : one-cycle lookup request
//   dds_data/dds_valid        : lookup result pulse
//   dds_ovf                   : sticky, a lookup was dropped
//   host_req/we/addr/wdata    : host command, held until host_gnt
//   host_gnt                  : pulse, command issued this cycle
//   host_rdata/host_rvalid    : host read result pulse
//   sram_addr/wdata/we        : registered SRAM command
//   sram_rdata                : SRAM read data, one cycle after capture
module lut_sram_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dds_req,
  input  logic [AW-1:0] dds_addr,
  output logic [DW-1:0] dds_data,
  output logic          dds_valid,
  output logic          dds_ovf,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  output logic          sram_we,
  input  logic [DW-1:0] sram_rdata
);

  typedef struct packed {
    logic vld;
    logic host;
  } tag_t;

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  logic [AW-1:0] fifo_q [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    cnt;
  logic [7:0]    wait_cnt;
  tag_t          tag1;
  tag_t          tag2;

  logic          forced;
  logic          host_ok;
  logic          pick_host;
  logic          pop;
  logic          live;
  logic          push;
  logic          drop;
  logic          rd_issue;
  logic [AW-1:0] nxt_addr;

  // host_gnt is registered, so the host still holds host_req in the
  // grant cycle; that cycle must not be taken as a new command.
  assign host_ok = host_req && !host_gnt;
  assign forced  = host_ok && (wait_cnt == MAX_W);

  always_comb begin
    pick_host = 1'b0;
    pop       = 1'b0;
    live      = 1'b0;
    if (forced) begin
      pick_host = 1'b1;
    end else if (cnt != 2'd0) begin
      pop = 1'b1;
    end else if (dds_req) begin
      live = 1'b1;
    end else if (host_ok) begin
      pick_host = 1'b1;
    end
  end

  // A pop in the same cycle frees a slot for the live request.
  assign push = dds_req && !live
             && ((cnt != 2'd2) || pop);
  assign drop = dds_req && !live && !push;

  assign rd_issue = pop || live
                 || (pick_host && !host_we);

  always_comb begin
    nxt_addr = '0;
    unique case (1'b1)
      pick_host: nxt_addr = host_addr;
      pop:       nxt_addr = fifo_q[rd_ptr];
      live:      nxt_addr = dds_addr;
      default:   nxt_addr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      cnt       <= 2'd0;
      dds_ovf   <= 1'b0;
      wait_cnt  <= 8'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= dds_addr;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + 2'(push) - 2'(pop);
      if (drop) begin
        dds_ovf <= 1'b1;
      end
      if (pick_host || host_gnt || !host_req) begin
        wait_cnt <= 8'd0;
      end else if (wait_cnt != MAX_W) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we    <= 1'b0;
      host_gnt   <= 1'b0;
      tag1       <= '0;
      tag2       <= '0;
    end else begin
      sram_addr  <= nxt_addr;
      sram_we    <= pick_host && host_we;
      sram_wdata <= (pick_host && host_we)
                  ? host_wdata : '0;
      host_gnt   <= pick_host;
      tag1       <= '{vld: rd_issue, host: pick_host};
      tag2       <= tag1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dds_data    <= '0;
      dds_valid   <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      dds_valid   <= tag2.vld && !tag2.host;
      host_rvalid <= tag2.vld && tag2.host;
      if (tag2.vld && !tag2.host) begin
        dds_data <= sram_rdata;
      end
      if (tag2.vld && tag2.host) begin
        host_rdata <= sram_rdata;
      end
    end
  end

endmodule
